multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the IR opcode and drives per-state datapath controls, including the 2-bit ALU operation class {aluop1, aluop0}.
- The ALU control decoder consumes that class together with the funct bits. This block is the producer end of that interface.
- Also counts retired instructions and flags unsupported opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  6  opcode, IR[31:26]; stable from DECODE onward.
- zero  input  1  ALU zero flag.
- pcen  output  1  PC write enable = pcwrite | (pcwritecond & zero).
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  IR load enable.
- memtoreg  output  1  register write data select: 1=MDR.
- regdst  output  1  destination register select: 1=rd, 0=rt.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A select: 0=PC, 1=A.
- alusrcb  output  2  ALU B select: 00=B, 01=const 4, 10=imm, 11=imm<<2.
- aluop1  output  1  ALU class, MSB.
- aluop0  output  1  ALU class, LSB.
- pcsource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- illegal_op  output  1  one-cycle flag: unsupported opcode seen in DECODE.
- instret  output  CNT_W  count of retired instructions.
- state  output  4  current state code, for debug.

Behaviour:
- ALU class encoding on {aluop1, aluop0}:
  - 00 = add
  - 01 = sub
  - 10 = R-type, decoded by funct
  - 11 = ori
- Supported opcodes:
  - R-type = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - j = 000010
  - ori = 001101
- Moore outputs, decoded combinationally from registered state. pcen and illegal_op also depend on inputs.
- Any output not listed for a state is 0.
- States (code: name: asserted outputs -> next state):
  - 0 FETCH: memread, irwrite, alusrcb=01, aluop=00, pcwrite, pcsource=00 -> DECODE.
  - 1 DECODE: alusrcb=11, aluop=00 -> next state by op:
    - lw/sw -> MEMADR
    - R -> EXEC
    - beq -> BRANCH
    - j -> JUMP
    - ori -> ORIEX
    - any other op -> FETCH, with illegal_op=1 for this cycle.
  - 2 MEMADR: alusrca=1, alusrcb=10, aluop=00 -> MEMRD if op=lw, else MEMWR.
  - 3 MEMRD: memread, iord -> MEMWB.
  - 4 MEMWB: regwrite, memtoreg -> FETCH; retires.
  - 5 MEMWR: memwrite, iord -> FETCH; retires.
  - 6 EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - 7 ALUWB: regdst, regwrite -> FETCH; retires.
  - 8 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsource=01 -> FETCH; retires.
  - 9 JUMP: pcwrite, pcsource=10 -> FETCH; retires.
  - 10 ORIEX: alusrca=1, alusrcb=10, aluop=11 -> ORIWB.
  - 11 ORIWB: regwrite, regdst=0 -> FETCH; retires.
  - 12-15 (unreachable): all outputs 0 -> FETCH; not counted.
- Instruction latency in cycles, FETCH to return to FETCH:
  - lw = 5
  - sw = 4
  - R = 4
  - ori = 4
  - beq = 3
  - j = 3
  - illegal = 2
- instret:
  - Increments by 1 on the clock edge leaving a retiring state.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes are not counted.
- Reset:
  - rst_n low immediately sets state=FETCH and instret=0.
  - While rst_n is low, every control output is forced to 0, including pcen and illegal_op.
  - Reset mid-instruction abandons it with no retire count.
  - First rising clk edge after rst_n rises: the FETCH outputs are active in the cycle before that edge, and the FSM advances to DECODE on it.
- beq: pcen=zero in the BRANCH cycle only. pcwritecond has no effect in any other state.
- op changes outside DECODE/MEMADR are ignored. op is sampled only for transitions out of those two states.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0, state=0, instret=0. Release -> FETCH outputs: memread=1, irwrite=1, pcen=1, alusrcb=01, aluop=00.
- lw (op=100011) -> state sequence 0,1,2,3,4,0. In state 2: aluop=00, alusrcb=10. In state 4: regwrite=1, memtoreg=1. instret becomes 1.
- R-type (op=000000) then ori (op=001101):
  - EXEC has {aluop1,aluop0}=10; ALUWB has regdst=1.
  - ORIEX has aluop=11, alusrcb=10; ORIWB has regdst=0, regwrite=1.
  - instret +2 after 8 cycles.
- beq (op=000100) with zero=1 -> pcen=1 and pcsource=01 in BRANCH, aluop=01. Repeat with zero=0 -> pcen=0. Both retire.
- Illegal op=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, instret unchanged.
- Async reset mid-instruction: assert rst_n=0 during MEMRD of a lw -> outputs 0 immediately without waiting for clk, state=0, instret=0. Separately, preload instret to 0xFFFF and retire one instruction -> instret=0x0000 (wrap).

Source files
------------

// File: rtl/multicycle_control.sv
// +--------------------------------------------------------------------------+
// | multicycle_control: main control FSM for a multicycle MIPS datapath,     |
// | with a retired-instruction counter and an unsupported-opcode flag.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  output logic             pcen,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             aluop1,
  output logic             aluop0,
  output logic [1:0]       pcsource,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11
  } state_t;

  localparam logic [5:0] C_OP_R   = 6'b000000;
  localparam logic [5:0] C_OP_LW  = 6'b100011;
  localparam logic [5:0] C_OP_SW  = 6'b101011;
  localparam logic [5:0] C_OP_BEQ = 6'b000100;
  localparam logic [5:0] C_OP_J   = 6'b000010;
  localparam logic [5:0] C_OP_ORI = 6'b001101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
  logic       w_irwrite, w_memtoreg, w_regdst, w_regwrite, w_alusrca;
  logic [1:0] w_alusrcb, w_aluop, w_pcsource;
  logic       w_illegal, w_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_pcsource    = 2'b00;
    w_illegal     = 1'b0;
    w_retire      = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        w_alusrcb = 2'b11;
        case (op)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_R:           state_d = S_EXEC;
          C_OP_BEQ:         state_d = S_BRANCH;
          C_OP_J:           state_d = S_JUMP;
          C_OP_ORI:         state_d = S_ORIEX;
          default: begin
            state_d   = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        state_d   = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_retire   = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
        w_retire      = 1'b1;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
        w_retire   = 1'b1;
      end
      S_ORIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 2'b11;
        state_d   = S_ORIWB;
      end
      S_ORIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = w_retire ? instret_q + CNT_W'(1) : instret_q;

  // Reset gates every control output, including the input-dependent ones.
  assign pcen       = rst_n & (w_pcwrite | (w_pcwritecond & zero));
  assign iord       = rst_n & w_iord;
  assign memread    = rst_n & w_memread;
  assign memwrite   = rst_n & w_memwrite;
  assign irwrite    = rst_n & w_irwrite;
  assign memtoreg   = rst_n & w_memtoreg;
  assign regdst     = rst_n & w_regdst;
  assign regwrite   = rst_n & w_regwrite;
  assign alusrca    = rst_n & w_alusrca;
  assign alusrcb    = rst_n ? w_alusrcb : 2'b00;
  assign aluop1     = rst_n & w_aluop[1];
  assign aluop0     = rst_n & w_aluop[0];
  assign pcsource   = rst_n ? w_pcsource : 2'b00;
  assign illegal_op = rst_n & w_illegal;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

`default_nettype wire
